param_stack: RTL and testbench
==============================

PARAM_STACK -- requirements
Module: param_stack

Interface
REQ-001 Parameter WIDTH, default 8, entry width in bits (location word: [WIDTH-1:WIDTH/2] = X, [WIDTH/2-1:0] = Y).
REQ-002 Parameter DEPTH, default 64, number of entries; SHALL be a power of two, at least 2.
REQ-003 Derived parameter CNT_W = log2(DEPTH)+1, width of the occupancy count.
REQ-004 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-005 Port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Port clear, input, 1, synchronous flush request.
REQ-008 Port push, input, 1, write din onto the stack this cycle.
REQ-009 Port pop, input, 1, remove the top entry into dout this cycle.
REQ-010 Port din, input, WIDTH, data to push.
REQ-011 Port dout, output, WIDTH, registered popped data.
REQ-012 Port dout_valid, output, 1, one-cycle strobe: dout was updated by the last edge.
REQ-013 Port top, output, WIDTH, combinational peek of the current top entry.
REQ-014 Port count, output, CNT_W, current occupancy, 0..DEPTH.
REQ-015 Port empty, output, 1, high when count == 0.
REQ-016 Port full, output, 1, high when count == DEPTH.
REQ-017 Port overflow, output, 1, sticky: a push was rejected.
REQ-018 Port underflow, output, 1, sticky: a pop was rejected.

Function
REQ-019 Storage: DEPTH x WIDTH array; entry i holds the (i+1)-th oldest live item; index count-1 is the top.
REQ-020 Priority per edge: rst > clear > push/pop operations.
REQ-021 Push only, not full: mem[count] <= din; count <= count+1; dout/dout_valid unchanged/0.
REQ-022 Push only, full: no write; count unchanged; overflow <= 1; dout_valid <= 0.
REQ-023 Pop only, not empty: dout <= mem[count-1]; dout_valid <= 1; count <= count-1.
REQ-024 Pop only, empty: count unchanged; dout holds; dout_valid <= 0; underflow <= 1.
REQ-025 Push and pop together, not empty (including full): replace top: dout <= old mem[count-1]; mem[count-1] <= din; dout_valid <= 1; count unchanged; no flag set.
REQ-026 Push and pop together, empty: bypass: dout <= din; dout_valid <= 1; count stays 0; no write; no flag set.
REQ-027 Neither push nor pop: all state held; dout_valid <= 0.
REQ-028 dout_valid SHALL be high for exactly one cycle per accepted pop; latency from pop edge to dout valid is one clock.
REQ-029 top = mem[count-1] when not empty, else all zeros; reflects the state after the last edge, no added latency.
REQ-030 empty and full SHALL be combinational decodes of count; never both high.
REQ-031 overflow and underflow, once set, SHALL hold until rst or clear.
REQ-032 clear: count <= 0; overflow <= 0; underflow <= 0; dout_valid <= 0; dout holds; push/pop that cycle ignored.
REQ-033 count SHALL never exceed DEPTH nor wrap below 0 under any input sequence.

Reset
REQ-034 On rst high at a rising edge: count = 0, dout = 0, dout_valid = 0, overflow = 0, underflow = 0; push/pop/clear ignored.
REQ-035 Array contents are not reset; no entry is observable until re-pushed, since top reads zero while empty.
REQ-036 rst asserted mid-sequence (stack partially filled) SHALL yield empty = 1 on the following cycle; earlier pushed data is never popped afterwards.

Verification
REQ-037 Reset, push 0x12, 0x34, 0x56 -> count=3, top=0x56; pop x3 -> dout 0x56, 0x34, 0x12 on successive cycles, dout_valid high each, then empty=1.
REQ-038 DEPTH=4: push 5 values 0xA0..0xA4 -> count=4, full=1, overflow=1 after 5th; pops return 0xA3, 0xA2, 0xA1, 0xA0.
REQ-039 From empty: pop -> underflow=1, dout_valid=0, count=0; then push+pop with din=0x77 -> dout=0x77, dout_valid=1, count=0.
REQ-040 Stack holding 0x11, 0x22: push+pop with din=0x99 -> dout=0x22, count=2, top=0x99; then pop -> dout=0x99.
REQ-041 With count=3 and overflow=1: assert clear with push=1 -> count=0, overflow=0, empty=1, top=0x00; next push 0x05 -> top=0x05, count=1.
REQ-042 With count=2: assert rst together with pop -> dout=0x00, dout_valid=0, count=0 after the edge.

Source files
------------

// File: rtl/param_stack.sv
// param_stack: parameterised LIFO stack with registered pop data, combinational
// top-of-stack peek, occupancy count and sticky overflow/underflow flags.
// Ports:
//   clk, rst        - sole clock, synchronous active-high reset
//   clear           - synchronous flush (count and flags to zero, dout held)
//   push, pop, din  - stack operations; both together replace the top entry
//   dout,dout_valid - registered popped data and its one-cycle strobe
//   top             - combinational peek of the current top entry (0 when empty)
//   count           - occupancy 0..DEPTH
//   empty, full     - combinational decodes of count
//   overflow        - sticky: a push was rejected
//   underflow       - sticky: a pop was rejected
module param_stack #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 64,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [WIDTH-1:0] top,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             we_c;
  logic [AW-1:0]    waddr_c;
  logic [AW-1:0]    top_idx_c;
  logic             empty_c;
  logic             full_c;

  assign empty_c   = (count_q == '0);
  assign full_c    = (count_q == CNT_W'(DEPTH));
  // Index of the top entry; only meaningful while not empty.
  assign top_idx_c = AW'(count_q - CNT_W'(1));

  // Next-state decode of one operation per edge; rst is applied in the register block.
  always_comb begin
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;
    we_c         = 1'b0;
    waddr_c      = '0;

    if (clear) begin
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (full_c) begin
            overflow_d = 1'b1;
          end else begin
            we_c    = 1'b1;
            waddr_c = AW'(count_q);
            count_d = count_q + CNT_W'(1);
          end
        end
        2'b01: begin
          if (empty_c) begin
            underflow_d = 1'b1;
          end else begin
            dout_d       = mem_q[top_idx_c];
            dout_valid_d = 1'b1;
            count_d      = count_q - CNT_W'(1);
          end
        end
        2'b11: begin
          // Replace the top entry, or bypass din straight to dout when empty.
          dout_valid_d = 1'b1;
          if (empty_c) begin
            dout_d = din;
          end else begin
            dout_d  = mem_q[top_idx_c];
            we_c    = 1'b1;
            waddr_c = top_idx_c;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Storage array is not reset; stale entries are hidden because top reads zero while empty.
  always_ff @(posedge clk) begin
    if (!rst && we_c) begin
      mem_q[waddr_c] <= din;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign count      = count_q;
  assign empty      = empty_c;
  assign full       = full_c;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;
  assign top        = empty_c ? '0 : mem_q[top_idx_c];

endmodule

// File: tb/tb_param_stack.sv
// Self-checking bench for param_stack (DEPTH=4): directed sequences plus a short
// random run, checked against a queue-based behavioural stack and a dout scoreboard.
module tb_param_stack;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clear = 1'b0;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [WIDTH-1:0] top;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .push       (push),
    .pop        (pop),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .top        (top),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  logic [WIDTH-1:0] model_q [$];
  logic [WIDTH-1:0] sb_q [$];
  logic [WIDTH-1:0] m_dout = '0;
  logic             m_ov = 1'b0;
  logic             m_un = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // One clock: update the model, drive inputs, then compare all outputs after the edge.
  task automatic step(input logic r, input logic c, input logic ps, input logic pp,
                      input logic [WIDTH-1:0] d);
    logic             e_dv;
    logic [WIDTH-1:0] e_top;
    e_dv = 1'b0;
    if (r) begin
      model_q.delete();
      m_dout = '0;
      m_ov = 1'b0;
      m_un = 1'b0;
    end else if (c) begin
      model_q.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else if (ps && pp) begin
      e_dv = 1'b1;
      if (model_q.size() == 0) begin
        m_dout = d;
      end else begin
        m_dout = model_q[$];
        model_q[$] = d;
      end
    end else if (ps) begin
      if (model_q.size() < DEPTH) model_q.push_back(d);
      else m_ov = 1'b1;
    end else if (pp) begin
      if (model_q.size() > 0) begin
        m_dout = model_q.pop_back();
        e_dv = 1'b1;
      end else begin
        m_un = 1'b1;
      end
    end
    if (e_dv) sb_q.push_back(m_dout);

    rst = r; clear = c; push = ps; pop = pp; din = d;
    @(posedge clk);
    #1;
    rst = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0;

    chk("dout_valid", 32'(dout_valid), 32'(e_dv));
    if (dout_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_valid", 32'(dout_valid), 32'(0));
      end else begin
        chk("dout", 32'(dout), 32'(sb_q.pop_front()));
      end
    end else begin
      chk("dout_hold", 32'(dout), 32'(m_dout));
    end
    e_top = (model_q.size() > 0) ? model_q[$] : '0;
    chk("count", 32'(count), 32'(model_q.size()));
    chk("top", 32'(top), 32'(e_top));
    chk("empty", 32'(empty), 32'(model_q.size() == 0));
    chk("full", 32'(full), 32'(model_q.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ov));
    chk("underflow", 32'(underflow), 32'(m_un));
  endtask

  initial begin
    // Reset state
    step(1, 0, 0, 0, 8'h00);
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_dout", 32'(dout), 32'h00);
    chk("rst_empty", 32'(empty), 32'(1));

    // Basic LIFO order
    step(0, 0, 1, 0, 8'h12);
    step(0, 0, 1, 0, 8'h34);
    step(0, 0, 1, 0, 8'h56);
    chk("lifo_count3", 32'(count), 32'(3));
    chk("lifo_top56", 32'(top), 32'h56);
    step(0, 0, 0, 1, 8'h00);
    chk("lifo_pop1", 32'(dout), 32'h56);
    step(0, 0, 0, 1, 8'h00);
    chk("lifo_pop2", 32'(dout), 32'h34);
    step(0, 0, 0, 1, 8'h00);
    chk("lifo_pop3", 32'(dout), 32'h12);
    chk("lifo_empty", 32'(empty), 32'(1));
    step(0, 0, 0, 0, 8'h00);

    // Fill past capacity
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 8'(8'hA0 + i));
    chk("ovf_count4", 32'(count), 32'(4));
    chk("ovf_full", 32'(full), 32'(1));
    chk("ovf_flag", 32'(overflow), 32'(1));
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 8'h00);
      chk("ovf_pop", 32'(dout), 32'(8'hA3 - i));
    end
    chk("ovf_sticky", 32'(overflow), 32'(1));
    step(0, 1, 0, 0, 8'h00);

    // Underflow and empty bypass
    step(0, 0, 0, 1, 8'h00);
    chk("unf_flag", 32'(underflow), 32'(1));
    chk("unf_dv", 32'(dout_valid), 32'(0));
    step(0, 0, 1, 1, 8'h77);
    chk("byp_dout", 32'(dout), 32'h77);
    chk("byp_count", 32'(count), 32'(0));
    step(0, 1, 0, 0, 8'h00);

    // Replace top
    step(0, 0, 1, 0, 8'h11);
    step(0, 0, 1, 0, 8'h22);
    step(0, 0, 1, 1, 8'h99);
    chk("rep_dout", 32'(dout), 32'h22);
    chk("rep_top", 32'(top), 32'h99);
    step(0, 0, 0, 1, 8'h00);
    chk("rep_pop", 32'(dout), 32'h99);
    step(0, 0, 0, 1, 8'h00);

    // Replace top while full
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 8'(8'h40 + i));
    step(0, 0, 1, 1, 8'hEE);
    chk("repfull_dout", 32'(dout), 32'h43);
    chk("repfull_noovf", 32'(overflow), 32'(0));

    // clear with push, count=3 and overflow=1
    step(0, 0, 1, 0, 8'h55);
    step(0, 0, 0, 1, 8'h00);
    chk("clr_pre_count", 32'(count), 32'(3));
    chk("clr_pre_ovf", 32'(overflow), 32'(1));
    step(0, 1, 1, 0, 8'hCC);
    chk("clr_count", 32'(count), 32'(0));
    chk("clr_top", 32'(top), 32'h00);
    step(0, 0, 1, 0, 8'h05);
    chk("clr_push_top", 32'(top), 32'h05);

    // rst together with pop
    step(0, 0, 1, 0, 8'h06);
    step(1, 0, 0, 1, 8'h00);
    chk("rstpop_dout", 32'(dout), 32'h00);
    chk("rstpop_dv", 32'(dout_valid), 32'(0));
    chk("rstpop_empty", 32'(empty), 32'(1));

    // Random operations
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
    end
    step(0, 0, 0, 0, 8'h00);
    chk("sb_drained", 32'(sb_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
